// File: rtl/sram_master_pkg.sv
// Shared types for the SRAM master: FSM states, access-size codes, wait counter width.
// Pure declarations: no latency, no flow control.
package sram_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WSETUP,
        WSTROBE,
        DONE
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Wide enough for WAIT_CYCLES up to 15.
    localparam int WAIT_W = 4;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/sram_master_if.sv
// Pipeline-side request/response bus of the SRAM master.
// master = requesting pipeline, slave = sram_master; req is only honoured while busy is low.
interface sram_master_if;
    logic        req;
    logic        rd_wr;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] req_addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic        busy;

    modport master (
        output req, rd_wr, size, sign_ext, req_addr, wdata,
        input  rdata, ack, err, busy
    );

    modport slave (
        input  req, rd_wr, size, sign_ext, req_addr, wdata,
        output rdata, ack, err, busy
    );
endinterface

// File: rtl/sram_lane.sv
// Big-endian lane extract/extend for loads and lane merge for read-modify-write stores.
// Purely combinational, zero latency, no flow control.
module sram_lane
    import sram_master_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word[31:24];
        case (offset)
            2'd0: byte_lane = word[31:24];
            2'd1: byte_lane = word[23:16];
            2'd2: byte_lane = word[15:8];
            2'd3: byte_lane = word[7:0];
            default: byte_lane = word[31:24];
        endcase
        // Offset 0 is the most significant half.
        half_lane = offset[1] ? word[15:0] : word[31:16];
    end

    always_comb begin
        load_val = word;
        merged   = wdata;
        case (size)
            SZ_BYTE: begin
                load_val = {{24{sign_ext & byte_lane[7]}}, byte_lane};
                merged   = word;
                case (offset)
                    2'd0: merged[31:24] = wdata[7:0];
                    2'd1: merged[23:16] = wdata[7:0];
                    2'd2: merged[15:8]  = wdata[7:0];
                    2'd3: merged[7:0]   = wdata[7:0];
                    default: merged     = word;
                endcase
            end
            SZ_HALF: begin
                load_val = {{16{sign_ext & half_lane[15]}}, half_lane};
                merged   = offset[1] ? {word[31:16], wdata[15:0]}
                                     : {wdata[15:0], word[15:0]};
            end
            default: begin
                load_val = word;
                merged   = wdata;
            end
        endcase
    end

endmodule

// File: rtl/sram_master.sv
// Single-port SRAM master: load = WAIT_CYCLES+2 cycles, word store = 3, sub-word RMW store = WAIT_CYCLES+4.
// One access in flight; req is ignored while busy. Sub-word stores need SRAM_MASTER_RMW_EN, else they return err.
module sram_master
    import sram_master_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    sram_master_if.slave bus,
    output logic        sram_cs,
    output logic        sram_oe,
    output logic        sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_din,
    input  logic [31:0] sram_dout
);

`ifdef SRAM_MASTER_RMW_EN
    localparam bit RMW_EN = 1'b1;
`else
    localparam bit RMW_EN = 1'b0;
`endif

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES);

    state_t state, state_nxt;

    logic [WAIT_W-1:0] wait_cnt;
    logic              rd_wr_q;
    logic              sign_ext_q;
    logic [1:0]        size_q;
    logic [1:0]        off_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              bad_req;
    logic              rd_last;
    logic [31:0]       load_val;
    logic [31:0]       merged;

    assign bad_req = is_misaligned(bus.size, bus.req_addr[1:0])
                   | (bus.rd_wr & (bus.size != SZ_WORD) & ~RMW_EN);
    assign rd_last = (wait_cnt == WAIT_LAST);

    sram_lane u_lane (
        .word     (sram_dout),
        .size     (size_q),
        .offset   (off_q),
        .sign_ext (sign_ext_q),
        .wdata    (wdata_q),
        .load_val (load_val),
        .merged   (merged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    if (bad_req) begin
                        state_nxt = DONE;
                    end else if (!bus.rd_wr || bus.size != SZ_WORD) begin
                        // Loads, and sub-word stores that need the old word first.
                        state_nxt = RD;
                    end else begin
                        state_nxt = WSETUP;
                    end
                end
            end
            RD: begin
                if (rd_last) begin
                    state_nxt = rd_wr_q ? WSETUP : DONE;
                end
            end
            WSETUP:  state_nxt = WSTROBE;
            WSTROBE: state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sram_cs    <= 1'b0;
            sram_oe    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_din   <= '0;
            wait_cnt   <= '0;
            rd_wr_q    <= 1'b0;
            sign_ext_q <= 1'b0;
            size_q     <= SZ_BYTE;
            off_q      <= 2'b00;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            // Strobes are decoded from the next state so they come straight off flops.
            sram_cs <= (state_nxt == RD) || (state_nxt == WSETUP) || (state_nxt == WSTROBE);
            sram_oe <= (state_nxt == RD);
            sram_we <= (state_nxt == WSTROBE);

            if (state == IDLE && bus.req) begin
                rd_wr_q    <= bus.rd_wr;
                sign_ext_q <= bus.sign_ext;
                size_q     <= bus.size;
                off_q      <= bus.req_addr[1:0];
                wdata_q    <= bus.wdata;
                wait_cnt   <= '0;
                sram_addr  <= {bus.req_addr[31:2], 2'b00};
                if (bus.rd_wr) begin
                    sram_din <= bus.wdata;
                end
                // err only moves on entry to DONE so it stays stable between acks.
                if (bad_req) begin
                    err_q <= 1'b1;
                end
            end

            if (state == RD) begin
                wait_cnt <= wait_cnt + 1'b1;
                if (rd_last) begin
                    if (rd_wr_q) begin
                        sram_din <= merged;
                    end else begin
                        rdata_q <= load_val;
                        err_q   <= 1'b0;
                    end
                end
            end

            if (state == WSTROBE) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;
    assign bus.ack   = (state == DONE);
    assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_sram_master.sv
// Directed bench for sram_master with a behavioural SRAM; cycle numbers count from the accepting edge.
module tb_sram_master;
    import sram_master_pkg::*;

    logic        clk;
    logic        reset;
    logic        sram_cs, sram_oe, sram_we;
    logic [31:0] sram_addr, sram_din, sram_dout;

    int tests_run = 0;
    int tests_failed = 0;

    sram_master_if bus ();

    sram_master #(.WAIT_CYCLES(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .sram_cs   (sram_cs),
        .sram_oe   (sram_oe),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_val;

    assign sram_dout = mem[sram_addr[9:2]];

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_val;
        end else if (sram_cs && sram_we) begin
            mem[sram_addr[9:2]] <= sram_din;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] val);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_idx = addr[9:2];
        pl_val = val;
        @(negedge clk);
        pl_en  = 1'b0;
    endtask

    // Issues one request and waits (bounded) for its ack; lat=0 means no ack seen.
    task automatic access(input logic rw, input logic [1:0] sz, input logic se,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic e,
                          output logic cs_seen);
        lat = 0;
        rd = '0;
        e = 1'b0;
        cs_seen = 1'b0;
        @(negedge clk);
        bus.req      = 1'b1;
        bus.rd_wr    = rw;
        bus.size     = sz;
        bus.sign_ext = se;
        bus.req_addr = addr;
        bus.wdata    = wd;
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            bus.req = 1'b0;
            if (sram_cs) cs_seen = 1'b1;
            if (bus.ack) begin
                lat = n;
                rd  = bus.rdata;
                e   = bus.err;
                break;
            end
        end
    endtask

    int          lat;
    logic [31:0] rd;
    logic        e;
    logic        cs_seen;
    logic [7:0]  ack_mask;
    int          ack_cnt;

    initial begin
        reset        = 1'b1;
        pl_en        = 1'b0;
        pl_idx       = '0;
        pl_val       = '0;
        bus.req      = 1'b0;
        bus.rd_wr    = 1'b0;
        bus.size     = SZ_WORD;
        bus.sign_ext = 1'b0;
        bus.req_addr = '0;
        bus.wdata    = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_strobes", {29'd0, sram_cs, sram_oe, sram_we}, 32'd0);
        check("rst_ack_err_busy", {29'd0, bus.ack, bus.err, bus.busy}, 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_addr", sram_addr, 32'd0);
        check("rst_din", sram_din, 32'd0);
        reset = 1'b0;

        // Word load
        preload(32'h100, 32'h1234_5678);
        access(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, lat, rd, e, cs_seen);
        check("ldw_lat", lat, 32'd3);
        check("ldw_rdata", rd, 32'h1234_5678);
        check("ldw_err", {31'd0, e}, 32'd0);
        repeat (3) @(negedge clk);
        check("ldw_rdata_hold", bus.rdata, 32'h1234_5678);

        // Byte loads, big-endian lane 1
        preload(32'h100, 32'h12F4_5678);
        access(1'b0, SZ_BYTE, 1'b1, 32'h101, 32'h0, lat, rd, e, cs_seen);
        check("ldb_s_lat", lat, 32'd3);
        check("ldb_s_rdata", rd, 32'hFFFF_FFF4);
        access(1'b0, SZ_BYTE, 1'b0, 32'h101, 32'h0, lat, rd, e, cs_seen);
        check("ldb_u_rdata", rd, 32'h0000_00F4);
        access(1'b0, SZ_BYTE, 1'b1, 32'h103, 32'h0, lat, rd, e, cs_seen);
        check("ldb_lane3", rd, 32'h0000_0078);

        // Halfword loads
        preload(32'h104, 32'h7ABC_8001);
        access(1'b0, SZ_HALF, 1'b1, 32'h106, 32'h0, lat, rd, e, cs_seen);
        check("ldh_s_lo", rd, 32'hFFFF_8001);
        access(1'b0, SZ_HALF, 1'b1, 32'h104, 32'h0, lat, rd, e, cs_seen);
        check("ldh_s_hi", rd, 32'h0000_7ABC);

        // Word store
        access(1'b1, SZ_WORD, 1'b0, 32'h180, 32'hCAFE_F00D, lat, rd, e, cs_seen);
        check("stw_lat", lat, 32'd3);
        check("stw_err", {31'd0, e}, 32'd0);
        check("stw_mem", mem[8'h60], 32'hCAFE_F00D);
        check("stw_rdata_hold", rd, 32'h0000_7ABC);

        // Misaligned requests
        access(1'b0, SZ_WORD, 1'b0, 32'h102, 32'h0, lat, rd, e, cs_seen);
        check("mis_w_lat", lat, 32'd1);
        check("mis_w_err", {31'd0, e}, 32'd1);
        check("mis_w_cs", {31'd0, cs_seen}, 32'd0);
        access(1'b0, SZ_HALF, 1'b0, 32'h101, 32'h0, lat, rd, e, cs_seen);
        check("mis_h_err", {31'd0, e}, 32'd1);
        access(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, lat, rd, e, cs_seen);
        check("mis_sz3_err", {31'd0, e}, 32'd1);
        check("mis_sz3_cs", {31'd0, cs_seen}, 32'd0);

        // Sub-word stores
        preload(32'h200, 32'hAABB_CCDD);
`ifdef SRAM_MASTER_RMW_EN
        access(1'b1, SZ_HALF, 1'b0, 32'h202, 32'h0000_1234, lat, rd, e, cs_seen);
        check("rmw_h_lat", lat, 32'd5);
        check("rmw_h_err", {31'd0, e}, 32'd0);
        check("rmw_h_mem", mem[8'h80], 32'hAABB_1234);
        access(1'b1, SZ_BYTE, 1'b0, 32'h201, 32'h0000_0055, lat, rd, e, cs_seen);
        check("rmw_b_mem", mem[8'h80], 32'hAA55_1234);
`else
        access(1'b1, SZ_BYTE, 1'b0, 32'h201, 32'h0000_0055, lat, rd, e, cs_seen);
        check("stb_lat", lat, 32'd1);
        check("stb_err", {31'd0, e}, 32'd1);
        check("stb_cs", {31'd0, cs_seen}, 32'd0);
        check("stb_mem", mem[8'h80], 32'hAABB_CCDD);
`endif

        // Reset during WSTROBE
        @(negedge clk);
        bus.req      = 1'b1;
        bus.rd_wr    = 1'b1;
        bus.size     = SZ_WORD;
        bus.req_addr = 32'h300;
        bus.wdata    = 32'h1111_2222;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        check("wstrobe_we", {31'd0, sram_we}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rstmid_strobes", {29'd0, sram_cs, sram_oe, sram_we}, 32'd0);
        check("rstmid_busy_ack", {30'd0, bus.busy, bus.ack}, 32'd0);
        check("rstmid_rdata", bus.rdata, 32'd0);
        reset = 1'b0;
        ack_cnt = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (bus.ack) ack_cnt++;
        end
        check("rstmid_no_ack", ack_cnt, 32'd0);
        access(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, lat, rd, e, cs_seen);
        check("post_rst_lat", lat, 32'd3);
        check("post_rst_rdata", rd, 32'h12F4_5678);

        // Back-to-back with req held high
        @(negedge clk);
        bus.req      = 1'b1;
        bus.rd_wr    = 1'b0;
        bus.size     = SZ_WORD;
        bus.sign_ext = 1'b0;
        bus.req_addr = 32'h100;
        @(posedge clk);
        ack_mask = '0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 8) bus.req = 1'b0;
            ack_mask[n-1] = bus.ack;
            if (n == 4) check("b2b_idle_gap", {31'd0, bus.busy}, 32'd0);
        end
        check("b2b_ack_mask", {24'd0, ack_mask}, 32'h0000_0044);
        repeat (2) @(negedge clk);
        check("b2b_idle_end", {31'd0, bus.busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
